beep_tone_gen: RTL and testbench

//  Tone generator stage directly downstream of the note decoder. It turns the decoder's
//  12-bit divider preset into a square wave that drives the buzzer pin.

---
 rtl/beep_pkg.sv | 16 +
 rtl/beep_tone_gen.sv | 124 ++++++++++++
 tb/tb_beep_tone_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/beep_pkg.sv
// Shared constants and state encoding for the buzzer tone path (note decoder + tone generator).
// GAP_CYCLES is only consumed when BEEP_GAP_EN is defined.
package beep_pkg;

    localparam int              CNT_W      = 12;
    localparam logic [CNT_W-1:0] REST_CODE = {CNT_W{1'b1}};
    localparam int              GAP_CYCLES = 1000;
    localparam int              GAP_W      = $clog2(GAP_CYCLES);

    typedef enum logic [1:0] {
        REST = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } beep_state_e;

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave buzzer driver: half-period = (4096 - preset) clk_1M cycles, preset 12'hFFF = silence.
// Optional BEEP_GAP_EN inserts GAP_CYCLES of silence between two different pitches.
module beep_tone_gen
    import beep_pkg::*;
(
    input  logic             clk_1M,
    input  logic             rst,
    input  logic [CNT_W-1:0] music_data,
    output logic             beep,
    output logic             tone_tick,
    output logic             sounding,
    output logic [1:0]       state_dbg
);

`ifdef BEEP_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    beep_state_e      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic             beep_d;
    logic             tick_d;
`ifdef BEEP_GAP_EN
    logic [GAP_W-1:0] gap_cnt, gap_d;
`endif

    assign state_dbg = state;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        preset_d = preset_q;
        beep_d   = beep;
        tick_d   = 1'b0;
`ifdef BEEP_GAP_EN
        gap_d    = gap_cnt;
`endif
        case (state)
            REST: begin
                beep_d = 1'b0;
                cnt_d  = REST_CODE;
                if (music_data != REST_CODE) begin
                    cnt_d    = music_data;
                    preset_d = music_data;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Preset is only sampled at the reload, so a phase is never cut short.
                if (cnt != REST_CODE) begin
                    cnt_d = cnt + 1'b1;
                end else if (music_data == REST_CODE) begin
                    beep_d  = 1'b0;
                    tick_d  = beep;
                    state_d = REST;
                end else if (music_data == preset_q || !GAP_EN) begin
                    cnt_d    = music_data;
                    preset_d = music_data;
                    beep_d   = ~beep;
                    tick_d   = 1'b1;
                end
`ifdef BEEP_GAP_EN
                else begin
                    beep_d  = 1'b0;
                    tick_d  = beep;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end
`endif
            end
`ifdef BEEP_GAP_EN
            GAP: begin
                beep_d = 1'b0;
                if (gap_cnt != '0) begin
                    gap_d = gap_cnt - 1'b1;
                end else if (music_data == REST_CODE) begin
                    state_d = REST;
                end else begin
                    cnt_d    = music_data;
                    preset_d = music_data;
                    state_d  = RUN;
                end
            end
`endif
            default: begin
                beep_d  = 1'b0;
                cnt_d   = REST_CODE;
                state_d = REST;
            end
        endcase
    end

    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            state     <= REST;
            cnt       <= REST_CODE;
            preset_q  <= REST_CODE;
            beep      <= 1'b0;
            tone_tick <= 1'b0;
            sounding  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            preset_q  <= preset_d;
            beep      <= beep_d;
            tone_tick <= tick_d;
            sounding  <= (state_d == RUN);
        end
    end

`ifdef BEEP_GAP_EN
    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_d;
        end
    end
`endif

endmodule

// File: tb/tb_beep_tone_gen.sv
// Bench for beep_tone_gen: every tone_tick is scored as {beep, cycles since previous tick/load}.
// Expected tick records are queued as stimulus is applied.
module tb_beep_tone_gen;

    localparam int W = 17;

    logic        clk_1M;
    logic        rst;
    logic [11:0] music_data;
    logic        beep;
    logic        tone_tick;
    logic        sounding;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           last_tick = 0;
    int           tick_count = 0;

    beep_tone_gen dut (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .music_data (music_data),
        .beep       (beep),
        .tone_tick  (tone_tick),
        .sounding   (sounding),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk_1M = 1'b0;
    always #5 clk_1M = ~clk_1M;
    always @(posedge clk_1M) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rec(input logic b, input int interval);
        rec = {b, 16'(interval)};
    endfunction

    // scoreboard: pop one expected record per tick
    always @(negedge clk_1M) begin
        if (!rst && tone_tick) begin
            logic [W-1:0] obs;
            obs = rec(beep, cyc - last_tick);
            last_tick = cyc;
            tick_count = tick_count + 1;
            if (exp_q.size() == 0) chk("unexp_tick", 32'(tone_tick), 32'd0);
            else                   chk("tick", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks (called at negedge+1; the next posedge is the load edge)
    task automatic load_note(input logic [11:0] p);
        music_data = p;
        last_tick  = cyc + 1;
    endtask

    task automatic push_phases(input logic first_beep, input int first_len,
                               input int len, input int n);
        logic b;
        b = first_beep;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(rec(b, (i == 0) ? first_len : len));
            b = ~b;
        end
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() <= n) break;
            @(negedge clk_1M); #1;
        end
        chk(tag, exp_q.size(), n);
        if (exp_q.size() > n) exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk_1M); #1; end
    endtask

    initial begin
        rst = 1'b1;
        music_data = 12'hFFF;
        #1;
        chk("rst_beep", beep, 0);
        chk("rst_tick", tone_tick, 0);
        chk("rst_sounding", sounding, 0);
        chk("rst_state", state_dbg, 0);
        idle(3);
        rst = 1'b0;

        // 1: rest code for 10000 cycles -> silence
        idle(10000);
        chk("rest_ticks", tick_count, 0);
        chk("rest_beep", beep, 0);
        chk("rest_sounding", sounding, 0);
        chk("rest_state", state_dbg, 0);

        // 2: minimum half-period (2 cycles)
        load_note(12'hFFE);
        push_phases(1'b1, 2, 2, 8);
        wait_q(7, 20, "ffe_first");
        chk("ffe_sounding", sounding, 1);
        chk("ffe_state", state_dbg, 1);
        wait_q(0, 40, "ffe_drain");
        music_data = 12'hFFF;   // beep currently 0: no tick on the way to REST
        idle(10);
        chk("ffe_off_sounding", sounding, 0);
        chk("ffe_off_beep", beep, 0);

        // 3: 1000-cycle phases, then a mid-phase switch to 500-cycle phases
        load_note(12'd3096);
        push_phases(1'b1, 1000, 1000, 2);
        wait_q(1, 1200, "p1000_rise");
        chk("p1000_beep_hi", beep, 1);
        idle(500);
        music_data = 12'd3596;
`ifdef BEEP_GAP_EN
        push_phases(1'b1, 1500, 500, 3);
`else
        push_phases(1'b1, 500, 500, 3);
`endif
        wait_q(0, 5000, "p500_drain");

        // 4: rest code at the next reload; beep is high so the fall ticks
        music_data = 12'hFFF;
        push_phases(1'b0, 500, 500, 1);
        wait_q(0, 700, "stop_drain");
        idle(5);
        chk("stop_sounding", sounding, 0);
        chk("stop_beep", beep, 0);
        chk("stop_state", state_dbg, 0);
        load_note(12'd3096);
        push_phases(1'b1, 1000, 1000, 2);
        wait_q(1, 1200, "restart_rise");

        // 5: async reset mid-high-phase
        idle(300);
        chk("pre_rst_beep", beep, 1);
        rst = 1'b1;
        #1;
        chk("async_beep", beep, 0);
        chk("async_sounding", sounding, 0);
        exp_q.delete();
        idle(3);
        chk("hold_state", state_dbg, 0);
        rst = 1'b0;
        last_tick = cyc + 1;
        push_phases(1'b1, 1000, 1000, 2);
        idle(5);
        chk("post_rst_sounding", sounding, 1);
        wait_q(0, 2500, "post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
